// File: rtl/dram_lsu_resp_pkg.sv
// +----------------------------------------------------------------------+
// | dram_lsu_resp_pkg : shared widths and responder FSM state encodings  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package dram_lsu_resp_pkg;

  localparam int XLEN    = 32;
  localparam int PC_SIZE = 32;

  localparam logic [1:0] DRAM_ST_IDLE = 2'b00;
  localparam logic [1:0] DRAM_ST_WAIT = 2'b01;
  localparam logic [1:0] DRAM_ST_RESP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = DRAM_ST_IDLE,
    ST_WAIT = DRAM_ST_WAIT,
    ST_RESP = DRAM_ST_RESP
  } dram_state_e;

endpackage

`default_nettype wire

// File: rtl/dram_sp_array.sv
// +----------------------------------------------------------------------+
// | dram_sp_array : single-port synchronous RAM, registered read port    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dram_sp_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Output register only moves on a read, so it naturally holds the last word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sirv_gnrl_dffs.sv
// +----------------------------------------------------------------------+
// | sirv_gnrl_dfflr / sirv_gnrl_dffr : general async-reset flop cells    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

module sirv_gnrl_dffr #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= '0;
    end else begin
      qout <= dnxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_lsu_resp.sv
// +----------------------------------------------------------------------+
// | dram_lsu_resp : LSU-facing data-RAM responder with wait-state FSM    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dram_lsu_resp
  import dram_lsu_resp_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int AW      = 12,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lsu_ram_valid,
  input  logic               lsu_ram_rd,
  input  logic               lsu_ram_wr,
  input  logic [PC_SIZE-1:0] lsu_ram_addr,
  input  logic [XLEN-1:0]    lsu_ram_wdata,
  output logic [XLEN-1:0]    ram_lsu_rdata,
  output logic               ram_lsu_ready,
  output logic               ram_busy
);

  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  dram_state_e     state_q, state_d;
  logic [1:0]      state_raw_q;
  logic [1:0]      cnt_q, cnt_d;
  logic            op_wr_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdata_q;
  logic            rvld_q, rvld_d;

  logic            w_accept;
  logic            w_in_idle;
  logic            w_op_wr;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_wdata;
  logic            w_commit;
  logic            w_we;
  logic            w_re;
  logic [XLEN-1:0] w_arr_rdata;
  logic            w_addr_unused;

  assign state_q       = dram_state_e'(state_raw_q);
  assign w_in_idle     = (state_q == ST_IDLE);
  assign ram_lsu_ready = (state_q == ST_RESP);
  assign ram_busy      = ~w_in_idle;
  assign w_accept      = lsu_ram_valid & (lsu_ram_rd | lsu_ram_wr) & w_in_idle & ~ram_lsu_ready;
  assign w_addr_unused = ^lsu_ram_addr[PC_SIZE-1:AW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With LATENCY==1 the array is touched on the accept edge itself, before the
  // capture registers load, so the live request is muxed in while idle.
  assign w_op_wr  = w_in_idle ? lsu_ram_wr : op_wr_q;
  assign w_idx    = w_in_idle ? lsu_ram_addr[AW-1:0] : idx_q;
  assign w_wdata  = w_in_idle ? lsu_ram_wdata : wdata_q;
  assign w_commit = (state_d == ST_RESP) & (state_q != ST_RESP);
  assign w_we     = w_commit & w_op_wr;
  assign w_re     = w_commit & ~w_op_wr;
  assign rvld_d   = rvld_q | w_re;

  sirv_gnrl_dffr #(.DW(2)) u_state_dff (
    .dnxt (state_d),
    .qout (state_raw_q),
    .clk  (clk),
    .rst_n(rst_n)
  );

  sirv_gnrl_dffr #(.DW(2)) u_cnt_dff (
    .dnxt (cnt_d),
    .qout (cnt_q),
    .clk  (clk),
    .rst_n(rst_n)
  );

  sirv_gnrl_dffr #(.DW(1)) u_rvld_dff (
    .dnxt (rvld_d),
    .qout (rvld_q),
    .clk  (clk),
    .rst_n(rst_n)
  );

  sirv_gnrl_dfflr #(.DW(1 + AW + XLEN)) u_cap_dff (
    .lden (w_accept),
    .dnxt ({lsu_ram_wr, lsu_ram_addr[AW-1:0], lsu_ram_wdata}),
    .qout ({op_wr_q, idx_q, wdata_q}),
    .clk  (clk),
    .rst_n(rst_n)
  );

  dram_sp_array #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (XLEN)
  ) u_array (
    .clk    (clk),
    .we_i   (w_we),
    .re_i   (w_re),
    .addr_i (w_idx),
    .wdata_i(w_wdata),
    .rdata_o(w_arr_rdata)
  );

  // The array read register is not reset; gating it gives a zero rdata out of reset.
  assign ram_lsu_rdata = rvld_q ? w_arr_rdata : '0;

endmodule

`default_nettype wire

// File: doc/dram_lsu_resp.md
Name: dram_lsu_resp

Overview:
- Data-RAM responder: the memory-side end of the LSU-to-RAM request interface.
- Accepts word-addressed read/write requests from the LSU and returns read data plus a ready pulse after a programmable number of wait states.
- Holds the last read word stable so the LSU can merge sub-word store data (read-modify-write).
- Sits between the LSU and the on-chip data memory; ITA register accesses never reach it.

Parameters:
- DEPTH, 4096: number of XLEN-bit words in the array (power of two).
- AW, 12: index width, log2(DEPTH).
- LATENCY, 1: cycles from request acceptance to ready pulse; legal range 1..4.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- lsu_ram_valid  input  1  request valid
- lsu_ram_rd  input  1  read request
- lsu_ram_wr  input  1  write request (already trap-gated upstream)
- lsu_ram_addr  input  PC_SIZE  word address (byte address >> 2)
- lsu_ram_wdata  input  XLEN  full-word write data (already merged)
- ram_lsu_rdata  output  XLEN  read data, held until the next accepted read
- ram_lsu_ready  output  1  one-cycle completion pulse
- ram_busy  output  1  request accepted, ready not yet returned (debug/perf)

Behaviour:
- Reset (async, rst_n low): ram_lsu_rdata=0, ram_lsu_ready=0, ram_busy=0, wait counter=0, FSM=IDLE. Array contents are not reset.
- Reset mid-operation drops the pending request. A pending write is not committed unless its commit edge already occurred.
- Accept condition: lsu_ram_valid & (lsu_ram_rd | lsu_ram_wr) & FSM==IDLE & ~ram_lsu_ready.
  - The ~ready term stops a valid still held high in the ready cycle from being re-accepted.
- On accept:
  - Register op (wr has priority if rd and wr are both high), index = lsu_ram_addr[AW-1:0], and wdata.
  - Upper address bits are ignored (the address wraps modulo DEPTH).
- States:
  - IDLE: accept → WAIT, with counter = LATENCY-1. If LATENCY==1, go straight to RESP.
  - WAIT: counter decrements each cycle; at 0 → RESP.
  - RESP: ram_lsu_ready=1 for exactly this cycle, then → IDLE.
- Read:
  - The array is read at the captured index.
  - ram_lsu_rdata updates on the edge that enters RESP and is valid when ready is high.
  - It holds the same value through later write transactions and idle cycles.
- Write:
  - The array is written with the captured wdata on the edge that enters RESP.
  - ram_lsu_rdata is unchanged.
  - A read issued after ready returns the new data.
- Latency: ready is asserted LATENCY cycles after the accept cycle. Throughput is one request per LATENCY+1 cycles.
- ram_busy=1 in WAIT and RESP.
- Inputs are ignored while not IDLE. The LSU keeps them stable anyway, but only the captured copies are used.
- valid low or rd=wr=0 in IDLE: no action, and ready stays 0.
- LSU sequence for a store: read phase, then write phase.
  - The read ready pulse advances the LSU.
  - The write is accepted in the first IDLE cycle after RESP, and ready pulses again LATENCY cycles later.
- No error response; misaligned and trap handling are upstream.

Decomposition:
- Shared defines (mcu_defines): XLEN, PC_SIZE.
- Local constants: FSM state encodings IDLE=2'b00, WAIT=2'b01, RESP=2'b10. These go into mcu_defines as DRAM_ST_* so the bench can probe state.
- State, counter and capture registers use the existing sirv_gnrl_dfflr / dffr flops.
- One sub-module: dram_sp_array, a single-port synchronous array (DEPTH×XLEN, write-enable, registered read). It is kept separate so it can be swapped for an SRAM macro.

Test Plan:
- LATENCY=1, array preloaded with word[5]=0xDEADBEEF; valid=1, rd=1, addr=5 → ready pulses exactly 1 cycle later with rdata=0xDEADBEEF. rdata is still 0xDEADBEEF 10 cycles later.
- Store sequence, LATENCY=1: read addr=7 (word=0x11223344), then write addr=7 with wdata=0x112233AA → two single-cycle ready pulses 2 cycles apart. A following read of addr=7 returns 0x112233AA, and rdata stayed 0x11223344 across the write phase.
- LATENCY=3: read addr=0 → ready high exactly 3 cycles after accept; ram_busy high for 3 cycles; valid held high throughout causes no second accept.
- Address wrap, DEPTH=4096: write addr=0x1003 with 0xCAFE0001, then read addr=3 → returns 0xCAFE0001.
- rd=1 and wr=1 in the same cycle with wdata=0x55AA55AA at addr=9 → treated as a write; a later read of 9 returns 0x55AA55AA; rdata is unchanged by the dual request.
- Async reset asserted in WAIT with a pending write to addr=2 (old value 0x0) → ready, busy and rdata go to 0 immediately. After release, a read of addr=2 returns 0x0 and the next request is accepted normally.
